// File: rtl/axi4lite_arbiter.sv
// ============================================================================
// Module      : axi4lite_arbiter
// Description : Two-master round-robin arbiter onto a single AXI4-lite slave
//               port; write and read paths arbitrate independently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_arbiter #(
    parameter  int ADDRSIZE = 5,
    localparam int RSIZE    = 1 << (ADDRSIZE - 1),
    localparam int DSIZE    = 1 << ADDRSIZE
) (
    input  logic                 aclk,
    input  logic                 reset,
    // master side
    input  logic [2*RSIZE-1:0]   m_awaddr,
    input  logic [1:0]           m_awvalid,
    output logic [1:0]           m_awready,
    input  logic [2*RSIZE-1:0]   m_wdata,
    input  logic [1:0]           m_wvalid,
    output logic [1:0]           m_wready,
    output logic [1:0]           m_bresp,
    output logic [1:0]           m_bvalid,
    input  logic [1:0]           m_bready,
    input  logic [2*DSIZE-1:0]   m_araddr,
    input  logic [1:0]           m_arvalid,
    output logic [1:0]           m_arready,
    output logic [RSIZE-1:0]     m_rdata,
    output logic [1:0]           m_rresp,
    output logic [1:0]           m_rvalid,
    input  logic [1:0]           m_rready,
    // slave side
    output logic [RSIZE-1:0]     s_awaddr,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [RSIZE-1:0]     s_wdata,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    input  logic [1:0]           s_bresp,
    input  logic                 s_bvalid,
    output logic                 s_bready,
    output logic [DSIZE-1:0]     s_araddr,
    output logic                 s_arvalid,
    input  logic                 s_arready,
    input  logic [RSIZE-1:0]     s_rdata,
    input  logic [1:0]           s_rresp,
    input  logic                 s_rvalid,
    output logic                 s_rready,
    // grants
    output logic [1:0]           wr_grant,
    output logic [1:0]           rd_grant
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t    r_wr_state, w_wr_state_nxt;
    r_state_t    r_rd_state, w_rd_state_nxt;
    logic [1:0]  r_wr_grant, w_wr_grant_nxt;
    logic [1:0]  r_rd_grant, w_rd_grant_nxt;
    logic        r_wr_last,  w_wr_last_nxt;
    logic        r_rd_last,  w_rd_last_nxt;
    logic        r_aw_done,  w_aw_done_nxt;
    logic        r_w_done,   w_w_done_nxt;

    logic        w_wr_sel, w_rd_sel;
    logic [1:0]  w_wr_req, w_rd_req;
    logic        w_wr_pick, w_rd_pick;

    // Grant index; an idle (zero) grant selects master 0 for the data buses.
    assign w_wr_sel = r_wr_grant[1];
    assign w_rd_sel = r_rd_grant[1];

    assign w_wr_req  = m_awvalid & m_wvalid;
    assign w_rd_req  = m_arvalid;
    // Under contention serve whichever master was not served last.
    assign w_wr_pick = (w_wr_req == 2'b11) ? ~r_wr_last : w_wr_req[1];
    assign w_rd_pick = (w_rd_req == 2'b11) ? ~r_rd_last : w_rd_req[1];

    assign s_awaddr = w_wr_sel ? m_awaddr[2*RSIZE-1:RSIZE] : m_awaddr[RSIZE-1:0];
    assign s_wdata  = w_wr_sel ? m_wdata[2*RSIZE-1:RSIZE]  : m_wdata[RSIZE-1:0];
    assign s_araddr = w_rd_sel ? m_araddr[2*DSIZE-1:DSIZE] : m_araddr[DSIZE-1:0];

    assign m_bresp  = s_bresp;
    assign m_rdata  = s_rdata;
    assign m_rresp  = s_rresp;
    assign wr_grant = r_wr_grant;
    assign rd_grant = r_rd_grant;

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
            r_wr_grant <= 2'b00;
            r_rd_grant <= 2'b00;
            r_wr_last  <= 1'b1;
            r_rd_last  <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_wr_grant <= w_wr_grant_nxt;
            r_rd_grant <= w_rd_grant_nxt;
            r_wr_last  <= w_wr_last_nxt;
            r_rd_last  <= w_rd_last_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_grant_nxt = r_wr_grant;
        w_wr_last_nxt  = r_wr_last;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        s_awvalid      = 1'b0;
        s_wvalid       = 1'b0;
        s_bready       = 1'b0;
        m_awready      = 2'b00;
        m_wready       = 2'b00;
        m_bvalid       = 2'b00;
        case (r_wr_state)
            W_IDLE: begin
                if (|w_wr_req) begin
                    w_wr_state_nxt = W_ADDR;
                    w_wr_grant_nxt = w_wr_pick ? 2'b10 : 2'b01;
                    w_wr_last_nxt  = w_wr_pick;
                end
            end
            W_ADDR: begin
                // AW and W may complete in either order or together.
                s_awvalid           = m_awvalid[w_wr_sel] & ~r_aw_done;
                s_wvalid            = m_wvalid[w_wr_sel]  & ~r_w_done;
                m_awready[w_wr_sel] = s_awready & ~r_aw_done;
                m_wready[w_wr_sel]  = s_wready  & ~r_w_done;
                w_aw_done_nxt       = r_aw_done | (s_awvalid & s_awready);
                w_w_done_nxt        = r_w_done  | (s_wvalid  & s_wready);
                if (w_aw_done_nxt && w_w_done_nxt)
                    w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_bready           = m_bready[w_wr_sel];
                m_bvalid[w_wr_sel] = s_bvalid;
                if (s_bvalid && m_bready[w_wr_sel]) begin
                    w_wr_state_nxt = W_IDLE;
                    w_wr_grant_nxt = 2'b00;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_grant_nxt = r_rd_grant;
        w_rd_last_nxt  = r_rd_last;
        s_arvalid      = 1'b0;
        s_rready       = 1'b0;
        m_arready      = 2'b00;
        m_rvalid       = 2'b00;
        case (r_rd_state)
            R_IDLE: begin
                if (|w_rd_req) begin
                    w_rd_state_nxt = R_ADDR;
                    w_rd_grant_nxt = w_rd_pick ? 2'b10 : 2'b01;
                    w_rd_last_nxt  = w_rd_pick;
                end
            end
            R_ADDR: begin
                s_arvalid           = m_arvalid[w_rd_sel];
                m_arready[w_rd_sel] = s_arready;
                if (s_arvalid && s_arready)
                    w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_rready           = m_rready[w_rd_sel];
                m_rvalid[w_rd_sel] = s_rvalid;
                if (s_rvalid && m_rready[w_rd_sel]) begin
                    w_rd_state_nxt = R_IDLE;
                    w_rd_grant_nxt = 2'b00;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

endmodule

`default_nettype wire
